// File: rtl/arith_div_seq.sv
// arith_div_seq: multi-cycle restoring shift-subtract divider, one quotient
// bit per clock, start/done handshake, C = inexact, V = error.
// Optional feature macro: ARITH_DIV_SIGNED_EN (two's-complement operands,
// truncating division, most-negative / -1 reported through V).
module arith_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             C,
  output logic             V,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;          // original dividend (div-by-zero rem, signs)
  logic [WIDTH-1:0] b_q, b_d;          // divisor magnitude
  logic [WIDTH-1:0] prem_q, prem_d;    // partial remainder
  logic [WIDTH-1:0] shift_q, shift_d;  // dividend bits out, quotient bits in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial_p, trial_diff;

`ifdef ARITH_DIV_SIGNED_EN
  logic qneg_q, qneg_d;   // quotient must be negated at the end
  logic ovf_q, ovf_d;     // most-negative / -1

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
    neg_f = ~x + WIDTH'(1);
  endfunction

  // Magnitudes feed the unsigned core; the most-negative value maps to 2^(W-1).
  assign a_mag = A[WIDTH-1] ? neg_f(A) : A;
  assign b_mag = B[WIDTH-1] ? neg_f(B) : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  // Trial subtraction is WIDTH+1 bits; its top bit is the borrow (P < B).
  assign trial_p    = {prem_q, shift_q[WIDTH-1]};
  assign trial_diff = trial_p - {1'b0, b_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: divide-by-zero skips CALC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (B == '0) ? S_FIN : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; results only change in FIN.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    prem_d  = prem_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
`ifdef ARITH_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = b_mag;
          prem_d  = '0;
          shift_d = a_mag;
          cnt_d   = CW'(WIDTH - 1);
`ifdef ARITH_DIV_SIGNED_EN
          qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
          ovf_d   = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        if (trial_diff[WIDTH] == 1'b0) begin
          prem_d  = trial_diff[WIDTH-1:0];
          shift_d = {shift_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d  = trial_p[WIDTH-1:0];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        if (b_q == '0) begin
          quot_d = '1;
          rem_d  = a_q;
          c_d    = 1'b0;
          v_d    = 1'b1;
        end else begin
`ifdef ARITH_DIV_SIGNED_EN
          if (ovf_q) begin
            quot_d = {1'b1, {(WIDTH-1){1'b0}}};
            rem_d  = '0;
            c_d    = 1'b0;
            v_d    = 1'b1;
          end else begin
            quot_d = qneg_q ? neg_f(shift_q) : shift_q;
            rem_d  = a_q[WIDTH-1] ? neg_f(prem_q) : prem_q;
            c_d    = (prem_q != '0);
            v_d    = 1'b0;
          end
`else
          quot_d = shift_q;
          rem_d  = prem_q;
          c_d    = (prem_q != '0);
          v_d    = 1'b0;
`endif
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      prem_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ARITH_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      prem_q  <= prem_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      c_q     <= c_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ARITH_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign C    = c_q;
  assign V    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_arith_div_seq.sv
// Scoreboard bench for arith_div_seq (WIDTH=4): expected results are queued
// at start and popped when done pulses.
module tb_arith_div_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] quot, rem;
  logic         c_o, v_o, busy, done;

  always #5 clk = ~clk;

  arith_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
    .quot(quot), .rem(rem), .C(c_o), .V(v_o), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } res_t;

  res_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  int           n_pushed = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_quot = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
`ifdef ARITH_DIV_SIGNED_EN
    int sa, sb;
`endif
    if (b == '0) begin
      r.q = '1; r.r = a; r.c = 1'b0; r.v = 1'b1;
    end else begin
`ifdef ARITH_DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(2 ** (W - 1)) && sb == -1) begin
        r.q = W'(2 ** (W - 1)); r.r = '0; r.v = 1'b1;
      end else begin
        r.q = W'(sa / sb); r.r = W'(sa % sb); r.v = 1'b0;
      end
`else
      r.q = a / b;
      r.r = a % b;
      r.v = 1'b0;
`endif
      r.c = (r.r != '0) && !r.v;
    end
    return r;
  endfunction

  // Scoreboard monitor: compare every done pulse against the queue head.
  always @(posedge clk) begin : mon
    res_t e;
    #1;
    if (done) begin
      done_cnt++;
      check_eq("done_single", {31'd0, prev_done}, 32'd0);
      check_eq("busy_at_done", {31'd0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("quot", quot, e.q);
        check_eq("rem", rem, e.r);
        check_eq("C", c_o, e.c);
        check_eq("V", v_o, e.v);
        last_quot = e.q;
      end
    end
    prev_done = done;
  end

  // Drive one start now (just after an edge); return edges up to done,
  // counting the start edge as 1, and the number of busy samples.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output int busy_cycles);
    start = 1'b1; a_in = a; b_in = b;
    sb_q.push_back(model(a, b));
    n_pushed++;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = '0;
    edges = 1; busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      check_eq("hold_quot", quot, last_quot);
      @(posedge clk); #1;
      edges++;
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e, bc, cnt;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_quot", quot, 32'd0);
    check_eq("rst_rem", rem, 32'd0);
    check_eq("rst_C", c_o, 32'd0);
    check_eq("rst_V", v_o, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_done", done, 32'd0);
    last_quot = '0;
    @(posedge clk); #1;

    run_op(4'd13, 4'd3, e, bc);
    check_eq("lat_13_3", e, 32'd6);
    check_eq("busy_13_3", bc, 32'd5);
    @(posedge clk); #1;
    run_op(4'd9, 4'd0, e, bc);
    check_eq("lat_div0", e, 32'd2);
    check_eq("busy_div0", bc, 32'd1);
    // Back-to-back: each run_op returns in the done cycle.
    run_op(4'd15, 4'd1, e, bc);
    check_eq("lat_15_1", e, 32'd6);
    run_op(4'd0, 4'd5, e, bc);
    check_eq("lat_0_5", e, 32'd6);
    run_op(4'd3, 4'd7, e, bc);
    check_eq("lat_3_7", e, 32'd6);
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      run_op(ra, rb, e, bc);
      check_eq("lat_rand", e, (rb == '0) ? 32'd2 : 32'd6);
    end
    @(posedge clk); #1;
    check_eq("done_dropped", done, 32'd0);

    // start during CALC is ignored.
    start = 1'b1; a_in = 4'd14; b_in = 4'd2;
    sb_q.push_back(model(4'd14, 4'd2));
    n_pushed++;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_in = 4'd1; b_in = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; a_in = '0; b_in = '0;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("ign_done_seen", done, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("ign_done_count", done_cnt, n_pushed);

    // Reset in the third CALC cycle aborts without done.
    start = 1'b1; a_in = 4'd11; b_in = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_quot = '0;
    check_eq("abort_quot", quot, 32'd0);
    check_eq("abort_rem", rem, 32'd0);
    check_eq("abort_C", c_o, 32'd0);
    check_eq("abort_V", v_o, 32'd0);
    check_eq("abort_busy", busy, 32'd0);
    check_eq("abort_done", done, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_no_done", done_cnt, n_pushed);

    // start together with rst: reset wins.
    rst = 1'b1; start = 1'b1; a_in = 4'd5; b_in = 4'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_busy", busy, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_start_no_done", done_cnt, n_pushed);

    // Recovery, then the signed-feature operand pairs (model covers both builds).
    run_op(4'd10, 4'd3, e, bc);
    check_eq("lat_10_3", e, 32'd6);
    run_op(4'b1001, 4'd2, e, bc);
    check_eq("lat_9_2", e, 32'd6);
    run_op(4'b1000, 4'b1111, e, bc);
    check_eq("lat_8_15", e, 32'd6);

    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("done_total", done_cnt, n_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
